conv2_chan_sched: RTL and testbench
===================================

CONV2_CHAN_SCHED -- requirements
Module: conv2_chan_sched

Interface
REQ-001 The block SHALL have parameter CHAN, default 10, giving the number of output channels to sequence (1..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 200, giving the maximum number of WAIT cycles before an error (used only with the macro).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to run all channels; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the run from any non-IDLE state.
REQ-007 The block SHALL have port conv_trigger, output, 1 bit: one-cycle start pulse to the convolution engine.
REQ-008 The block SHALL have port conv_chan, output, 4 bits: channel index presented to the engine.
REQ-009 The block SHALL have port conv_valid, input, 1 bit: engine completion pulse.
REQ-010 The block SHALL have port conv_out_chan, input, 4 bits: channel index reported by the engine with conv_valid.
REQ-011 The block SHALL have port chan_valid, output, 1 bit: channel result buffer ready for the consumer.
REQ-012 The block SHALL have port chan_idx, output, 4 bits: index of the channel offered.
REQ-013 The block SHALL have port chan_ready, input, 1 bit: consumer has taken the buffer.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last channel is accepted.
REQ-016 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-017 The state machine SHALL have the states IDLE, TRIG, WAIT, HAND and DONE, plus a 4-bit channel counter ctr.
REQ-018 IDLE with start=1 and abort=0 SHALL go to TRIG, clear ctr to 0 and clear err.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 TRIG SHALL drive conv_trigger=1 for exactly one cycle, then go to WAIT; conv_trigger SHALL be asserted in the cycle after start is sampled.
REQ-021 conv_chan SHALL equal ctr, held stable from TRIG through HAND, because the engine samples the channel every compute cycle.
REQ-022 In WAIT, conv_valid=1 with conv_out_chan==ctr SHALL go to HAND.
REQ-023 In WAIT, conv_valid=1 with conv_out_chan!=ctr SHALL set err=1 and go to IDLE without a done pulse.
REQ-024 In HAND, chan_valid=1 and chan_idx=ctr SHALL hold until chan_ready=1; a chan_ready already high on HAND entry SHALL complete the transfer that cycle.
REQ-025 A HAND transfer with ctr==CHAN-1 SHALL go to DONE; otherwise ctr SHALL increment and the next state SHALL be TRIG.
REQ-026 DONE SHALL drive done=1 for one cycle, then go to IDLE.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, deassert conv_trigger, chan_valid and done, and leave err unchanged.
REQ-028 abort SHALL take priority over every other transition; start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-029 conv_valid SHALL be ignored outside WAIT.
REQ-030 chan_ready SHALL be ignored outside HAND.
REQ-031 With CHAN=1, the sequence SHALL be TRIG, WAIT, HAND, DONE.

Reset
REQ-032 When rst=1, the block SHALL go to IDLE at the next edge with ctr=0, conv_trigger=0, conv_chan=0, chan_valid=0, chan_idx=0, busy=0, done=0 and err=0.
REQ-033 rst mid-run SHALL discard the run with no done pulse, and rst SHALL override abort and start.

Configuration
REQ-034 The macro CONV2_SCHED_TIMEOUT_EN SHALL control a WAIT-state timeout.
REQ-035 With CONV2_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-036 With CONV2_SCHED_TIMEOUT_EN defined, reaching TIMEOUT without conv_valid SHALL set err=1 and go to IDLE.
REQ-037 With CONV2_SCHED_TIMEOUT_EN undefined, the counter SHALL be absent, WAIT SHALL be unbounded, and err SHALL be set only by a channel mismatch.

Verification
REQ-038 Bench scenario, nominal run: CHAN=10 with an engine model answering 134 cycles after the trigger and chan_ready tied to 1 -> 10 conv_trigger pulses with conv_chan 0..9, chan_idx 0..9 in order, one done pulse, err=0.
REQ-039 Bench scenario, backpressure: chan_ready held 0 for 20 cycles on channel 3 -> chan_valid stays 1 with chan_idx=3 and no conv_trigger until acceptance; the channel 4 trigger follows one cycle after acceptance.
REQ-040 Bench scenario, mismatch: the engine returns conv_out_chan=5 while ctr=2 -> err=1, busy=0 next cycle, no done pulse; the next start clears err.
REQ-041 Bench scenario, abort: abort pulsed in WAIT of channel 6 -> IDLE next cycle, no further triggers, and start/abort together in IDLE keep busy=0.
REQ-042 Bench scenario, timeout: with CONV2_SCHED_TIMEOUT_EN, TIMEOUT=200 and the engine never responding -> err=1 after 200 WAIT cycles; without the macro, busy stays 1 after 1000 cycles.
REQ-043 Bench scenario, reset mid-run: rst=1 during HAND of channel 4 -> all outputs at their reset values next cycle, and a later start restarts at conv_chan=0.

Source files
------------

// File: rtl/conv2_chan_sched.sv
// conv2_chan_sched: sequences CHAN channels through a conv engine and hands each result to a consumer.
// Optional WAIT-state timeout enabled by defining CONV2_SCHED_TIMEOUT_EN.
module conv2_chan_sched #(
   parameter int CHAN    = 10,
   parameter int TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       conv_trigger,
   output logic [3:0] conv_chan,
   input  logic       conv_valid,
   input  logic [3:0] conv_out_chan,
   output logic       chan_valid,
   output logic [3:0] chan_idx,
   input  logic       chan_ready,
   output logic       busy,
   output logic       done,
   output logic       err
);
   typedef enum logic [2:0] {IDLE, TRIG, WAIT, HAND, DONE} state_t;
   state_t     r_state, w_state;
   logic [3:0] r_ctr, w_ctr;
   logic       r_err, w_err;
   logic       w_timeout;
   logic       w_last;
`ifdef CONV2_SCHED_TIMEOUT_EN
   logic [15:0] r_tmo;
   // Held at zero outside WAIT, so it restarts on every WAIT entry.
   always_ff @(posedge clk)
      r_tmo <= (rst || r_state != WAIT) ? 16'd0 : r_tmo + 16'd1;
   assign w_timeout = (r_tmo == 16'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_timeout = 1'b0;
`endif
   assign w_last = (r_ctr == 4'(CHAN - 1));
   always_comb begin
      w_state = r_state;
      w_ctr   = r_ctr;
      w_err   = r_err;
      if (r_state != IDLE && abort)
         w_state = IDLE;
      else
         case (r_state)
            IDLE: if (start && !abort) begin
               w_state = TRIG;
               w_ctr   = 4'd0;
               w_err   = 1'b0;
            end
            TRIG: w_state = WAIT;
            WAIT: if (conv_valid) begin
               w_state = (conv_out_chan == r_ctr) ? HAND : IDLE;
               w_err   = r_err | (conv_out_chan != r_ctr);
            end else if (w_timeout) begin
               w_state = IDLE;
               w_err   = 1'b1;
            end
            HAND: if (chan_ready) begin
               w_state = w_last ? DONE : TRIG;
               w_ctr   = w_last ? r_ctr : r_ctr + 4'd1;
            end
            DONE: w_state = IDLE;
            default: w_state = IDLE;
         endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ctr   <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_ctr   <= w_ctr;
         r_err   <= w_err;
      end
   end
   assign conv_trigger = (r_state == TRIG);
   assign conv_chan    = r_ctr;
   assign chan_valid   = (r_state == HAND);
   assign chan_idx     = r_ctr;
   assign busy         = (r_state != IDLE);
   assign done         = (r_state == DONE);
   assign err          = r_err;
endmodule

// File: tb/tb_conv2_chan_sched.sv
// tb_conv2_chan_sched: randomized bench for conv2_chan_sched with an engine/consumer model.
// Define CONV2_SCHED_TIMEOUT_EN for both files to exercise the timeout build.
module tb_conv2_chan_sched;
   localparam int CHAN    = 10;
   localparam int TIMEOUT = 200;
   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic       conv_valid = 1'b0, chan_ready = 1'b1;
   logic [3:0] conv_out_chan = 4'd0;
   logic       conv_trigger, chan_valid, busy, done, err;
   logic [3:0] conv_chan, chan_idx;
   int n_vec = 0, n_err = 0, cyc = 0, done_n = 0, hand_n = 0, last_acc = 0;
   int trig_q[$], xfer_q[$], trig_cyc[$], acc_cyc[$];
   int eng_lat = 10, eng_bad = -1, rdy_mode = 0, bp_ch = -1, bp_len = 0, bp_cnt = 0;
   bit eng_mute = 1'b0;

   conv2_chan_sched #(.CHAN(CHAN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .conv_trigger(conv_trigger), .conv_chan(conv_chan),
      .conv_valid(conv_valid), .conv_out_chan(conv_out_chan),
      .chan_valid(chan_valid), .chan_idx(chan_idx), .chan_ready(chan_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Scoreboard: expected channel order is simply the trigger count of the run.
   initial forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst) begin
         if (conv_trigger) begin
            chk("trig_ch", int'(conv_chan), trig_q.size());
            if (trig_q.size() > 0) chk("trig_gap", cyc, last_acc + 1);
            trig_q.push_back(int'(conv_chan));
            trig_cyc.push_back(cyc);
         end
         if (busy && trig_q.size() > 0) chk("conv_chan_hold", int'(conv_chan), trig_q[$]);
         if (chan_valid) chk("chan_idx", int'(chan_idx), trig_q.size() > 0 ? trig_q[$] : -1);
         if (chan_valid && int'(chan_idx) == bp_ch) hand_n++;
         if (chan_valid && chan_ready) begin
            xfer_q.push_back(int'(chan_idx));
            acc_cyc.push_back(cyc);
            last_acc = cyc;
         end
         if (done) done_n++;
      end
   end

   // Engine: answers eng_lat cycles after a trigger, optionally with a wrong channel.
   initial forever begin
      @(negedge clk);
      #1;
      if (conv_trigger && !eng_mute) begin
         repeat (eng_lat - 1) @(negedge clk);
         conv_out_chan = (int'(conv_chan) == eng_bad) ? 4'd5 : conv_chan;
         conv_valid = 1'b1;
         @(negedge clk);
         conv_valid = 1'b0;
      end
   end

   // Consumer: always ready, random, or stalling bp_len cycles on channel bp_ch.
   initial forever begin
      @(negedge clk);
      if (rdy_mode == 2 && chan_valid && int'(chan_idx) == bp_ch && bp_cnt < bp_len) begin
         chan_ready = 1'b0;
         bp_cnt++;
      end else
         chan_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic go();
      trig_q.delete(); xfer_q.delete(); trig_cyc.delete(); acc_cyc.delete();
      done_n = 0; hand_n = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy && k < max) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic full_check(input string t);
      chk({t, "_ntrig"}, trig_q.size(), CHAN);
      chk({t, "_nxfer"}, xfer_q.size(), CHAN);
      for (int i = 0; i < CHAN && i < xfer_q.size(); i++) chk({t, "_xfer"}, xfer_q[i], i);
      chk({t, "_done"}, done_n, 1);
      chk({t, "_err"}, int'(err), 0);
   endtask

   task automatic chk_reset_outs(input string t);
      chk({t, "_busy"}, int'(busy), 0);
      chk({t, "_done"}, int'(done), 0);
      chk({t, "_err"}, int'(err), 0);
      chk({t, "_trig"}, int'(conv_trigger), 0);
      chk({t, "_cvalid"}, int'(chan_valid), 0);
      chk({t, "_cchan"}, int'(conv_chan), 0);
      chk({t, "_cidx"}, int'(chan_idx), 0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst = 1'b0;
      @(negedge clk);
      eng_lat = 134;
      go();
      wait_idle(3000);
      full_check("nominal");
      for (int r = 0; r < 4; r++) begin
         eng_lat = $urandom_range(2, 40);
         rdy_mode = 1;
         go();
         wait_idle(3000);
         full_check("random");
      end
      rdy_mode = 2; bp_ch = 3; bp_len = 20; bp_cnt = 0;
      eng_lat = $urandom_range(2, 20);
      go();
      wait_idle(3000);
      full_check("bp");
      chk("bp_hand_cycles", hand_n, bp_len + 1);
      if (trig_cyc.size() > 4 && acc_cyc.size() > 3) chk("bp_gap", trig_cyc[4] - acc_cyc[3], 1);
      else chk("bp_gap_missing", trig_cyc.size(), CHAN);
      rdy_mode = 0; bp_ch = -1;
      eng_bad = 2;
      eng_lat = $urandom_range(2, 30);
      go();
      k = 0;
      do begin
         @(negedge clk);
         #2;
         k++;
      end while (!(conv_valid && conv_out_chan == 4'd5) && k < 2000);
      chk("mm_seen", int'(conv_valid), 1);
      @(negedge clk);
      #2;
      chk("mm_busy", int'(busy), 0);
      chk("mm_err", int'(err), 1);
      chk("mm_done", done_n, 0);
      chk("mm_ntrig", trig_q.size(), 3);
      eng_bad = -1;
      @(negedge clk);
      go();
      chk("mm_err_clear", int'(err), 0);
      wait_idle(3000);
      full_check("mm_rerun");
      eng_lat = 50;
      go();
      k = 0;
      while (trig_q.size() < 7 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("ab_reach", trig_q.size(), 7);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #2;
      chk("ab_busy", int'(busy), 0);
      chk("ab_trig", int'(conv_trigger), 0);
      chk("ab_cvalid", int'(chan_valid), 0);
      chk("ab_err", int'(err), 0);
      repeat (200) @(negedge clk);
      chk("ab_ntrig", trig_q.size(), 7);
      chk("ab_done", done_n, 0);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #2;
      chk("sa_busy0", int'(busy), 0);
      @(negedge clk);
      #2;
      chk("sa_busy1", int'(busy), 0);
      chk("sa_trig", int'(conv_trigger), 0);
      @(negedge clk);
      eng_mute = 1'b1;
      go();
`ifdef CONV2_SCHED_TIMEOUT_EN
      repeat (TIMEOUT) @(negedge clk);
      chk("to_busy_before", int'(busy), 1);
      @(negedge clk);
      chk("to_busy_after", int'(busy), 0);
      chk("to_err", int'(err), 1);
      chk("to_done", done_n, 0);
`else
      repeat (1000) @(negedge clk);
      chk("to_busy_hold", int'(busy), 1);
      chk("to_err", int'(err), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("to_abort", int'(busy), 0);
`endif
      eng_mute = 1'b0;
      rdy_mode = 2; bp_ch = 4; bp_len = 1000; bp_cnt = 0;
      eng_lat = $urandom_range(2, 20);
      go();
      k = 0;
      while (!(chan_valid && chan_idx == 4'd4) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rr_reach", int'(chan_idx), 4);
      repeat (3) @(negedge clk);
      rst = 1'b1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      #2;
      chk_reset_outs("rr");
      chk("rr_done", done_n, 0);
      rdy_mode = 0; bp_ch = -1;
      @(negedge clk);
      go();
      chk("rr_restart_chan", int'(conv_chan), 0);
      wait_idle(3000);
      full_check("rr_rerun");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
